// File: rtl/logic_unit_pkg.sv
// Shared types and the per-bit gate function for the pipelined logic unit.
//   op_e    : 3-bit opcode (AND, OR, NOT, NAND, NOR, XOR, XNOR, BUF)
//   flags_t : status flags that travel with each result
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } flags_t;

  // Single-bit gate evaluation; NOT and BUF look only at a.
  function automatic logic eval_bit(input op_e op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_BUF:  r = a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_eval.sv
// Combinational WIDTH-bit logic evaluation.
//   op     : opcode
//   a, b   : operands (b unused by NOT/BUF)
//   result : f(op, a, b)
module logic_unit_eval
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Bitwise ops are independent per bit lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign result[i] = eval_bit(op, a[i], b[i]);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
//   in_valid/in_ready   : operation handshake (in_ready combinational from out_ready)
//   in_op/in_chain      : opcode; chain replaces B with the last accepted result
//   in_a/in_b           : operands
//   out_valid/out_ready : result handshake
//   out_result          : registered result
//   out_zero/ones/parity: registered flags for out_result
//   txn_count           : results consumed, wrapping
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNTW-1:0]  txn_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] acc;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  flags_t           s2_flags;

  logic             s2_free_c;
  logic             accept_c;
  logic             s2_load_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH-1:0] f_res_c;
  flags_t           s1_flags_c;

  // Handshake chain: a stage frees up when its downstream drains this cycle.
  assign s2_free_c = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_free_c;
  assign accept_c  = in_valid & in_ready;
  assign s2_load_c = s1_valid & s2_free_c;

  assign b_eff_c = in_chain ? acc : in_b;

  logic_unit_eval #(.WIDTH(WIDTH)) u_eval (
    .op     (op_e'(in_op)),
    .a      (in_a),
    .b      (b_eff_c),
    .result (f_res_c)
  );

  // Flags are precomputed from stage 1 so they register alongside the result.
  assign s1_flags_c.zero   = ~|s1_res;
  assign s1_flags_c.ones   = &s1_res;
  assign s1_flags_c.parity = ^s1_res;

  // Stage 1: capture on accept; acc tracks the last accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      acc      <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_res   <= f_res_c;
      acc      <= f_res_c;
    end else if (s2_free_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else if (s2_load_c) begin
      s2_valid <= 1'b1;
      s2_res   <= s1_res;
      s2_flags <= s1_flags_c;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Completed-transaction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (s2_valid & out_ready) begin
      txn_count <= txn_count + CNTW'(1);
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_res;
  assign out_zero   = s2_flags.zero;
  assign out_ones   = s2_flags.ones;
  assign out_parity = s2_flags.parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, CNTW=4).
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_chain;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic [CNTW-1:0]  txn_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_t1 [8] = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};

  logic_unit_pipe #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_chain   (in_chain),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ones   (out_ones),
    .out_parity (out_parity),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic ch,
                       input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in_chain = ch;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // All eight ops back-to-back, A=F0 B=3C.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0, 8'hF0, 8'h3C);
      step();
      if (i == 0) begin
        chk("t1_latency", 32'(out_valid), 32'd0);
      end else begin
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", 32'(out_result), 32'(exp_t1[i-1]));
      end
    end
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    chk("t1_last", 32'(out_result), 32'h F0);
    chk("t1_txn7", 32'(txn_count), 32'd7);
    step();
    chk("t1_drained", 32'(out_valid), 32'd0);
    chk("t1_txn8", 32'(txn_count), 32'd8);

    // Chain: AND FF&0F, OR chain A0, XOR chain FF.
    drive(1'b1, 3'd0, 1'b0, 8'hFF, 8'h0F);
    step();
    drive(1'b1, 3'd1, 1'b1, 8'hA0, 8'h00);
    step();
    chk("chain_and", 32'(out_result), 32'h0F);
    drive(1'b1, 3'd5, 1'b1, 8'hFF, 8'h00);
    step();
    chk("chain_or", 32'(out_result), 32'hAF);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    chk("chain_xor", 32'(out_result), 32'h50);
    step();
    chk("chain_txn", 32'(txn_count), 32'd11);

    // Back-pressure: four BUF ops with the consumer stalled.
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 1'b0, 8'h11, 8'h00);
    step();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    drive(1'b1, 3'd7, 1'b0, 8'h22, 8'h00);
    step();
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_res11", 32'(out_result), 32'h11);
    drive(1'b1, 3'd7, 1'b0, 8'h33, 8'h00);
    step();
    chk("bp_hold", 32'(out_result), 32'h11);
    chk("bp_still_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    step();
    chk("bp_res22", 32'(out_result), 32'h22);
    drive(1'b1, 3'd7, 1'b0, 8'h44, 8'h00);
    step();
    chk("bp_res33", 32'(out_result), 32'h33);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    chk("bp_res44", 32'(out_result), 32'h44);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_txn", 32'(txn_count), 32'd15);

    // Flags: BUF 00, NOT 00, BUF 01.
    drive(1'b1, 3'd7, 1'b0, 8'h00, 8'h00);
    step();
    drive(1'b1, 3'd2, 1'b0, 8'h00, 8'h00);
    step();
    chk("fl0_flags", 32'({out_zero, out_ones, out_parity}), 32'b100);
    drive(1'b1, 3'd7, 1'b0, 8'h01, 8'h00);
    step();
    chk("flff_result", 32'(out_result), 32'hFF);
    chk("flff_flags", 32'({out_zero, out_ones, out_parity}), 32'b010);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    chk("fl1_flags", 32'({out_zero, out_ones, out_parity}), 32'b001);
    step();
    chk("fl_txn_wrapped", 32'(txn_count), 32'd2);

    // Reset mid-stream with a full, stalled pipeline.
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 1'b0, 8'h5A, 8'h00);
    step();
    drive(1'b1, 3'd7, 1'b0, 8'hA5, 8'h00);
    step();
    chk("mr_full", 32'({out_valid, in_ready}), 32'b10);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_txn", 32'(txn_count), 32'd0);
    chk("mr_result", 32'(out_result), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 8'hFF, 8'hFF);
    step();
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    chk("mr_acc_valid", 32'(out_valid), 32'd1);
    chk("mr_acc_zero", 32'(out_result), 32'h00);

    // Counter wrap: 17 consumed results from a clean reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'd7, 1'b0, 8'(i), 8'h00);
      step();
    end
    drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    chk("wrap_zero", 32'(txn_count), 32'd0);
    chk("wrap_last", 32'(out_result), 32'd16);
    step();
    chk("wrap_one", 32'(txn_count), 32'd1);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
